// File: rtl/init_seq_pkg.sv
// init_seq_pkg: shared state encoding and constants for the init reset sequencer
package init_seq_pkg;
   localparam int STATE_W = 3;
   localparam int SYNC_STAGES = 2;
   typedef enum logic [STATE_W-1:0] {
      IDLE      = 3'd0,
      WAIT_INIT = 3'd1,
      WAIT_LOCK = 3'd2,
      STABLE    = 3'd3,
      RELEASE   = 3'd4,
      RUN       = 3'd5,
      ERROR     = 3'd6
   } state_t;
endpackage

// File: rtl/init_seq_sync.sv
// init_seq_sync: multi-bit 2-FF synchroniser with synchronous active-low clear
module init_seq_sync
   import init_seq_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] stg;
   // shift each async bit through the stage chain; cleared during reset
   always_ff @(posedge CLK)
      if (!RESET_N) stg <= '0;
      else stg <= {stg[SYNC_STAGES-2:0], d};
   assign q = stg[SYNC_STAGES-1];
endmodule

// File: rtl/init_reset_sequencer.sv
// init_reset_sequencer: staged fabric reset release after device init and PLL lock (optional watchdog: INIT_SEQ_TIMEOUT_EN)
module init_reset_sequencer
   import init_seq_pkg::*;
#(
   parameter int NUM_DOMAINS        = 4,
   parameter int LOCK_STABLE_CYCLES = 16,
   parameter int RELEASE_GAP        = 8,
   parameter int REQUIRE_XCVR       = 0,
   parameter int REQUIRE_PCIE       = 0
`ifdef INIT_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES   = 1048576
`endif
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   DEVICE_INIT_DONE,
   input  logic                   SRAM_INIT_DONE,
   input  logic                   USRAM_INIT_DONE,
   input  logic                   XCVR_INIT_DONE,
   input  logic                   PCIE_INIT_DONE,
   input  logic                   AUTOCALIB_DONE,
   input  logic                   PLL_LOCK,
   output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
   output logic                   SEQ_DONE,
   output logic                   LOCK_LOST,
   output logic [STATE_W-1:0]     STATE
`ifdef INIT_SEQ_TIMEOUT_EN
   , output logic                 TIMEOUT_ERR
`endif
);
   localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES) + 1;
   localparam int GAP_W = $clog2(RELEASE_GAP) + 1;
   localparam int IDX_W = $clog2(NUM_DOMAINS) + 1;
   logic [6:0] syn;
   logic lock, init_ok, lost, lost_n;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [GAP_W-1:0] gap, gap_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [NUM_DOMAINS-1:0] dom, dom_n;
   init_seq_sync #(.WIDTH(7)) u_sync (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .d({PLL_LOCK, AUTOCALIB_DONE, PCIE_INIT_DONE, XCVR_INIT_DONE, USRAM_INIT_DONE, SRAM_INIT_DONE, DEVICE_INIT_DONE}),
      .q(syn)
   );
   assign lock = syn[6];
   assign init_ok = syn[0] && syn[1] && syn[2] && syn[5] && (syn[3] || REQUIRE_XCVR == 0) && (syn[4] || REQUIRE_PCIE == 0);
`ifdef INIT_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WD_W-1:0] wd, wd_n;
   logic waiting;
   assign waiting = state == WAIT_INIT || state == WAIT_LOCK;
   assign TIMEOUT_ERR = state == ERROR;
   // watchdog counts cycles spent in one wait state and restarts on any state change
   always_ff @(posedge CLK)
      if (!RESET_N) wd <= '0;
      else wd <= wd_n;
`endif
   // next state; dom is a thermometer code so each release step just widens it by one bit
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      gap_n = gap;
      idx_n = idx;
      dom_n = dom;
      lost_n = lost;
      case (state)
         IDLE: state_n = WAIT_INIT;
         WAIT_INIT: if (init_ok) state_n = WAIT_LOCK;
         WAIT_LOCK:
            if (lock) begin
               state_n = STABLE;
               cnt_n = '0;
            end
         STABLE:
            if (!lock) begin
               state_n = WAIT_LOCK;
               cnt_n = '0;
            end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
               state_n = RELEASE;
               idx_n = '0;
               gap_n = '0;
               dom_n = NUM_DOMAINS'(1);
            end else cnt_n = cnt + 1'b1;
         RELEASE:
            if (!lock) begin
               state_n = WAIT_LOCK;
               dom_n = '0;
            end else if (idx == IDX_W'(NUM_DOMAINS - 1)) state_n = RUN;
            else if (gap == GAP_W'(RELEASE_GAP - 1)) begin
               gap_n = '0;
               idx_n = idx + 1'b1;
               dom_n = dom | (dom << 1);
            end else gap_n = gap + 1'b1;
         RUN:
            if (!lock) begin
               state_n = WAIT_LOCK;
               dom_n = '0;
               lost_n = 1'b1;
            end
`ifdef INIT_SEQ_TIMEOUT_EN
         ERROR: dom_n = '0;
`endif
         default: state_n = IDLE;
      endcase
`ifdef INIT_SEQ_TIMEOUT_EN
      if (waiting && wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
         state_n = ERROR;
         dom_n = '0;
      end
      wd_n = (state_n != state || !waiting) ? '0 : wd + 1'b1;
`endif
   end
   // sequencer state register with synchronous active-low reset
   always_ff @(posedge CLK)
      if (!RESET_N) begin
         state <= IDLE;
         cnt <= '0;
         gap <= '0;
         idx <= '0;
         dom <= '0;
         lost <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         gap <= gap_n;
         idx <= idx_n;
         dom <= dom_n;
         lost <= lost_n;
      end
   assign DOMAIN_RESET_N = dom;
   assign SEQ_DONE = state == RUN;
   assign LOCK_LOST = lost;
   assign STATE = state;
endmodule

// File: tb/tb_init_reset_sequencer.sv
// tb_init_reset_sequencer: randomized scenarios checked by an interval-level reference model via event scoreboards
module tb_init_reset_sequencer;
   localparam int MAXC = 40000;
   localparam int NA = 4, LA = 16, GA = 8;
   localparam int NB = 3, LB = 7, GB = 5;
   localparam int NSCEN = 30;
   typedef struct {
      int         cyc;
      logic [12:0] v;
   } ev_t;
   logic CLK = 1'b0;
   logic rst_n, dev, sram, usram, xcvr, pcie, acal, pll;
   logic [NA-1:0] dom_a;
   logic [NB-1:0] dom_b;
   logic done_a, done_b, lost_a, lost_b;
   logic [2:0] st_a, st_b;
`ifdef INIT_SEQ_TIMEOUT_EN
   logic terr_a, terr_b;
`endif
   bit [6:0] iv [MAXC];
   bit rs [MAXC];
   logic [12:0] ex [MAXC];
   ev_t qa[$], qb[$];
   int errors = 0, checks = 0, cyc = 0, scen = -1;
   logic [12:0] la = '0, lb = '0;
   int nc [10] = '{22, 23, 38, 39, 46, 47, 55, 62, 63, 64};
   int ndm [10] = '{0, 0, 0, 1, 1, 3, 7, 7, 15, 15};
   int nd [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
   int nst [10] = '{2, 3, 3, 4, 4, 4, 4, 4, 4, 5};

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   init_reset_sequencer #(
      .NUM_DOMAINS(NA), .LOCK_STABLE_CYCLES(LA), .RELEASE_GAP(GA), .REQUIRE_XCVR(0), .REQUIRE_PCIE(0)
   ) dut_a (
      .CLK(CLK), .RESET_N(rst_n), .DEVICE_INIT_DONE(dev), .SRAM_INIT_DONE(sram), .USRAM_INIT_DONE(usram),
      .XCVR_INIT_DONE(xcvr), .PCIE_INIT_DONE(pcie), .AUTOCALIB_DONE(acal), .PLL_LOCK(pll),
      .DOMAIN_RESET_N(dom_a), .SEQ_DONE(done_a), .LOCK_LOST(lost_a), .STATE(st_a)
`ifdef INIT_SEQ_TIMEOUT_EN
      , .TIMEOUT_ERR(terr_a)
`endif
   );

   init_reset_sequencer #(
      .NUM_DOMAINS(NB), .LOCK_STABLE_CYCLES(LB), .RELEASE_GAP(GB), .REQUIRE_XCVR(1), .REQUIRE_PCIE(1)
   ) dut_b (
      .CLK(CLK), .RESET_N(rst_n), .DEVICE_INIT_DONE(dev), .SRAM_INIT_DONE(sram), .USRAM_INIT_DONE(usram),
      .XCVR_INIT_DONE(xcvr), .PCIE_INIT_DONE(pcie), .AUTOCALIB_DONE(acal), .PLL_LOCK(pll),
      .DOMAIN_RESET_N(dom_b), .SEQ_DONE(done_b), .LOCK_LOST(lost_b), .STATE(st_b)
`ifdef INIT_SEQ_TIMEOUT_EN
      , .TIMEOUT_ERR(terr_b)
`endif
   );

   function automatic int mn(int x, int y);
      return x < y ? x : y;
   endfunction

   function automatic bit sl(int u);
      return iv[u-2][6];
   endfunction

   function automatic bit okf(bit w, int u);
      bit [6:0] v;
      v = iv[u-2];
      return v[0] && v[1] && v[2] && v[5] && (!w || (v[3] && v[4]));
   endfunction

   task automatic put(int u, int st, bit l, bit dn, logic [7:0] dm);
      ex[u] = {3'(st), l, dn, dm};
   endtask

   task automatic setb(int b, int from, int to, bit v);
      for (int u = from; u <= to; u++) iv[u][b] = v;
   endtask

   // reference model: walks lock-high intervals of the synchronised inputs and
   // derives state/output timelines arithmetically, then queues every output change
   task automatic model(bit w, int c0, int ce);
      int n, lsc, gap, a, t, bb, d, r, rr, k;
      bit lost;
      logic [12:0] prev;
      n = w ? NB : NA;
      lsc = w ? LB : LA;
      gap = w ? GB : GA;
      for (int u = c0; u <= ce; u++) put(u, u == c0 ? 0 : 1, 0, 0, 0);
      a = -1;
      for (int u = c0 + 2; u <= ce; u++)
         if (okf(w, u)) begin
            a = u;
            break;
         end
      lost = 0;
      t = (a < 0) ? ce + 1 : a + 1;
      while (t <= ce) begin
         bb = t;
         while (bb <= ce && !sl(bb)) bb++;
         for (int u = t; u <= mn(bb, ce); u++) put(u, 2, lost, 0, 0);
         if (bb > ce) break;
         d = bb + 1;
         while (d <= bb + lsc && d <= ce && sl(d)) d++;
         if (d <= bb + lsc) begin
            for (int u = bb + 1; u <= mn(d, ce); u++) put(u, 3, lost, 0, 0);
            t = d + 1;
            continue;
         end
         for (int u = bb + 1; u <= mn(bb + lsc, ce); u++) put(u, 3, lost, 0, 0);
         r = bb + lsc + 1;
         rr = r + (n - 1) * gap + 1;
         d = r;
         while (d <= ce && sl(d)) d++;
         for (int u = r; u <= mn(d, ce); u++) begin
            k = mn((u - r) / gap + 1, n);
            put(u, u < rr ? 4 : 5, lost, u >= rr, 8'((1 << k) - 1));
         end
         if (d > ce) break;
         if (d >= rr) lost = 1;
         t = d + 1;
      end
      prev = '0;
      for (int u = c0; u <= ce + 1; u++) begin
         logic [12:0] v;
         v = (u > ce) ? 13'd0 : ex[u];
         if (v != prev) begin
            if (w) qb.push_back('{u, v});
            else qa.push_back('{u, v});
         end
         prev = v;
      end
   endtask

   task automatic gen(int s, int c0, output int ce);
      int ls, t, hl, rt;
      case (s)
         0: ls = 200;
         1: ls = 200;
         2: ls = 350;
         3: ls = 700;
         4: ls = 36;
         default: ls = $urandom_range(150, 450);
      endcase
      ce = c0 + ls;
      for (int u = c0; u <= ce + 2; u++) begin
         iv[u] = '0;
         rs[u] = u < ce;
      end
      case (s)
         0: begin
            for (int i = 0; i < 6; i++) setb(i, c0 + 7, ce, 1);
            setb(6, c0 + 17, ce, 1);
         end
         1: begin
            for (int i = 0; i < 6; i++) setb(i, c0 + 2, ce, 1);
            setb(6, c0 + 10, ce, 1);
            setb(6, c0 + 21, c0 + 21, 0);
         end
         2: begin
            for (int i = 0; i < 6; i++) setb(i, c0 + 2, ce, 1);
            setb(6, c0 + 10, ce, 1);
            setb(6, c0 + 150, c0 + 154, 0);
         end
         3: begin
            for (int i = 0; i < 6; i++) setb(i, i == 4 ? c0 + 497 : c0 + 2, ce, 1);
            setb(6, c0 + 10, ce, 1);
         end
         4: begin
            for (int i = 0; i < 6; i++) setb(i, c0 + 2, ce, 1);
            setb(6, c0 + 5, ce, 1);
         end
         default: begin
            for (int i = 0; i < 6; i++) begin
               rt = c0 + $urandom_range(0, 30);
               if (i == 4 && $urandom_range(0, 3) == 0) rt = c0 + $urandom_range(100, 600);
               setb(i, rt, ce, 1);
               if ($urandom_range(0, 4) == 0) setb(i, rt + $urandom_range(1, 100), ce, 0);
            end
            t = c0 + $urandom_range(0, 40);
            while (t <= ce) begin
               case ($urandom_range(0, 3))
                  0: hl = $urandom_range(1, 24);
                  1: hl = $urandom_range(16, 60);
                  2: hl = $urandom_range(60, 300);
                  default: hl = $urandom_range(1, 3);
               endcase
               setb(6, t, mn(t + hl - 1, ce), 1);
               t = t + hl + $urandom_range(1, 6);
            end
         end
      endcase
      for (int u = ce + 1; u <= ce + 2; u++) iv[u] = 7'($urandom);
   endtask

   task automatic apply(int t);
      rst_n = rs[t];
      {pll, acal, pcie, xcvr, usram, sram, dev} = iv[t];
   endtask

   task automatic observe(bit w, logic [12:0] cur);
      ev_t e;
      checks++;
      if ((w ? qb.size() : qa.size()) == 0) begin
         errors++;
         $display("FAIL %s unexpected_change cyc=%0d got=%h", w ? "dut_b" : "dut_a", cyc, cur);
         return;
      end
      if (w) e = qb.pop_front();
      else e = qa.pop_front();
      if (e.cyc != cyc || e.v !== cur)
         begin
            errors++;
            $display("FAIL %s event got cyc=%0d val=%h required cyc=%0d val=%h", w ? "dut_b" : "dut_a", cyc, cur, e.cyc, e.v);
         end
   endtask

   // monitor: every change of a DUT output tuple is matched against its scoreboard queue
   always @(negedge CLK)
      if (cyc >= 1) begin
         if ({st_a, lost_a, done_a, 8'(dom_a)} !== la) observe(0, {st_a, lost_a, done_a, 8'(dom_a)});
         if ({st_b, lost_b, done_b, 8'(dom_b)} !== lb) observe(1, {st_b, lost_b, done_b, 8'(dom_b)});
         la <= {st_a, lost_a, done_a, 8'(dom_a)};
         lb <= {st_b, lost_b, done_b, 8'(dom_b)};
      end

   // absolute nominal timing for the first scenario (flags at 10, lock at 20)
   always @(negedge CLK)
      if (scen == 0)
         for (int i = 0; i < 10; i++)
            if (cyc == nc[i]) begin
               checks++;
               if ({st_a, done_a, dom_a} !== {3'(nst[i]), 1'(nd[i]), 4'(ndm[i])}) begin
                  errors++;
                  $display("FAIL nominal cyc=%0d got st=%0d done=%0d dom=%b required st=%0d done=%0d dom=%b",
                           cyc, st_a, done_a, dom_a, nst[i], nd[i], 4'(ndm[i]));
               end
            end

   initial begin
      int c0, ce;
      for (int u = 0; u < 3; u++) begin
         rs[u] = 0;
         iv[u] = 7'($urandom);
      end
      apply(0);
      c0 = 3;
      for (int s = 0; s < NSCEN; s++) begin
         gen(s, c0, ce);
         model(0, c0, ce);
         model(1, c0, ce);
         scen = s;
         while (cyc < ce + 2) begin
            @(posedge CLK);
            #1;
            apply(cyc);
            if (cyc == c0) begin
               @(negedge CLK);
               checks++;
               if ({st_a, lost_a, done_a, dom_a, st_b, lost_b, done_b, dom_b} !== '0) begin
                  errors++;
                  $display("FAIL reset_state cyc=%0d got a=%0d/%b/%b/%b b=%0d/%b/%b/%b required all zero",
                           cyc, st_a, lost_a, done_a, dom_a, st_b, lost_b, done_b, dom_b);
               end
            end
         end
         c0 = ce + 3;
      end
      repeat (3) @(posedge CLK);
      checks++;
      if (qa.size() != 0) begin
         errors++;
         $display("FAIL dut_a missing_events got_pending=%0d required=0", qa.size());
      end
      checks++;
      if (qb.size() != 0) begin
         errors++;
         $display("FAIL dut_b missing_events got_pending=%0d required=0", qb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
